host_reg_port: RTL and testbench
================================

Name: host_reg_port

Overview:
- Host-side register access engine in the sclk domain.
- Decodes a byte-stream command protocol from the host link into writes and reads of a bank of dual-clock registers.
- Drives each register's sclk-side mask/value inputs and serialises the registers' sclk-side value outputs back to the host.
- Sits between the host byte FIFO and the register bank.

Parameters:
- NREGS, 16, number of registers in the bank (1..128).
- WIDTH, 16, width of every register in bits (1..64).
- WR_HOLD, 8, number of sclk cycles the write mask stays asserted per write (>=1).

Ports:
- sclk  input  1  system clock; all logic on posedge.
- srst  input  1  reset, asynchronous, active-high.
- rx_data  input  8  command/data byte from host.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  block accepts rx byte this cycle.
- tx_data  output  8  response byte to host.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  host accepts tx byte.
- reg_wmask  output  NREGS*WIDTH  per-register write mask; slice i = bits [i*WIDTH +: WIDTH].
- reg_wdata  output  WIDTH  write value shared by all registers.
- reg_rdata  input  NREGS*WIDTH  per-register current sclk-side value.

Behaviour:
- NB = ceil(WIDTH/8) data bytes per register, little-endian.
- A byte transfers on a posedge where valid and ready are both high.
- Command byte: bit7 = 1 write / 0 read; bits[6:0] = address. Address >= NREGS is out of range.
- States: IDLE, WDATA, WHOLD, RDATA.
- IDLE: rx_ready=1, tx_valid=0.
  - Write command -> WDATA, byte counter cleared.
  - Read command -> RDATA. At the accepting edge, snapshot the addressed slice of reg_rdata into the tx shift register; zero if out of range.
- WDATA: rx_ready=1.
  - Each byte shifts into reg_wdata at byte position count.
  - Bits above WIDTH are discarded.
  - After byte NB: go to WHOLD if in range, else IDLE.
- WHOLD: rx_ready=0.
  - Addressed slice of reg_wmask = all ones; all other slices = 0.
  - Lasts exactly WR_HOLD cycles, starting the cycle after the last data byte. Then IDLE, mask = 0.
  - Repeated capture by the register is idempotent. The hold covers the register's cross-domain busy window.
- RDATA: rx_ready=0, tx_valid=1 starting the cycle after the command byte.
  - tx_data = snapshot byte 0, then byte 1, ...
  - tx_data stays stable while tx_valid && !tx_ready.
  - After byte NB transfers: IDLE, tx_valid=0 in the following cycle.
- reg_wdata changes only in WDATA; it holds its last value otherwise.
- Read snapshot: reg_rdata changes after the command edge do not affect the bytes sent.
- Reset (srst high, asynchronous):
  - state=IDLE, counters=0, reg_wmask=0, reg_wdata=0, tx_valid=0, tx_data=0, rx_ready=0 while srst is high.
  - rx_ready=1 the first cycle after release.
  - Reset mid-operation aborts it: partial write data is discarded, no mask pulse is issued, and a pending read response is dropped.
- Throughput: no back-to-back overlap. A new command is accepted only in IDLE.

Decomposition:
- Package host_reg_pkg:
  - state enum (IDLE, WDATA, WHOLD, RDATA).
  - CMD_WRITE_BIT = 7, ADDR_BITS = 7.
  - function nbytes(width) returning ceil(width/8).
- No sub-module. Byte shift/serialise logic stays inline; the bank of register instances lives in the parent.

Test Plan (NREGS=4, WIDTH=16, WR_HOLD=8 unless stated):
- Write: rx 0x82,0x34,0x12 -> reg_wdata=0x1234; reg_wmask[47:32]=0xFFFF for exactly 8 cycles beginning the cycle after 0x12; other slices 0; rx_ready=0 during those 8 cycles.
- Read: reg1 rdata=0xBEEF, rx 0x01, then reg1 rdata changed to 0x0000 -> tx 0xEF then 0xBE; tx_valid falls after the second transfer.
- Backpressure: during the read above, hold tx_ready=0 for 5 cycles -> tx_data held at 0xEF, tx_valid=1 throughout, no byte lost or duplicated.
- Out of range:
  - rx 0x85,0xAA,0xBB -> reg_wmask stays 0; rx_ready=1 the next cycle.
  - rx 0x06 -> tx 0x00,0x00.
- Reset mid-write: rx 0x83,0x55, assert srst -> reg_wmask=0 and no pulse. After release, rx 0x80,0x01,0x00 -> slice 0 mask pulse with reg_wdata=0x0001.
- WIDTH=12: rx 0x80,0xCD,0xFB -> reg_wdata=0xBCD. Reading a register holding 0xBCD -> tx 0xCD,0x0B.

Source files
------------

// File: rtl/host_reg_pkg.sv
// Shared types and constants for the host register access engine.
package host_reg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WDATA = 2'd1,
      ST_WHOLD = 2'd2,
      ST_RDATA = 2'd3
   } state_e;

   localparam int CMD_WRITE_BIT = 7;
   localparam int ADDR_BITS     = 7;

   function automatic int nbytes(input int width);
      return (width + 7) / 8;
   endfunction

endpackage

// File: rtl/host_reg_port.sv
// Host byte-stream command decoder: writes/reads a bank of NREGS x WIDTH registers.
// Data bytes are little-endian; writes hold the mask for WR_HOLD cycles to cover the bank's CDC window.
module host_reg_port
   import host_reg_pkg::*;
#(
   parameter int NREGS   = 16,
   parameter int WIDTH   = 16,
   parameter int WR_HOLD = 8
) (
   input  logic                   sclk,
   input  logic                   srst,
   input  logic [7:0]             rx_data,
   input  logic                   rx_valid,
   output logic                   rx_ready,
   output logic [7:0]             tx_data,
   output logic                   tx_valid,
   input  logic                   tx_ready,
   output logic [NREGS*WIDTH-1:0] reg_wmask,
   output logic [WIDTH-1:0]       reg_wdata,
   input  logic [NREGS*WIDTH-1:0] reg_rdata
);

   localparam int NB = nbytes(WIDTH);
   localparam int CW = 4;
   localparam int HW = $clog2(WR_HOLD + 1);
   localparam logic [CW-1:0]        LAST_BYTE = CW'(NB - 1);
   localparam logic [HW-1:0]        HOLD_LAST = HW'(WR_HOLD - 1);
   localparam logic [ADDR_BITS:0]   NREGS_L   = (ADDR_BITS + 1)'(NREGS);

   state_e                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [HW-1:0]          hold_q, hold_d;
   logic [ADDR_BITS-1:0]   addr_q, addr_d;
   logic [WIDTH-1:0]       wdata_q, wdata_d;
   logic [NREGS*WIDTH-1:0] wmask_q, wmask_d;
   logic [NB*8-1:0]        tx_sh_q, tx_sh_d;

   logic             rx_fire, tx_fire, addr_in_range;
   logic [WIDTH-1:0] rd_slice;

   // rx_ready is forced low while reset is asserted, not just after it.
   assign rx_ready  = !srst && (state_q == ST_IDLE || state_q == ST_WDATA);
   assign tx_valid  = (state_q == ST_RDATA);
   assign tx_data   = tx_sh_q[7:0];
   assign reg_wmask = wmask_q;
   assign reg_wdata = wdata_q;

   assign rx_fire       = rx_valid && rx_ready;
   assign tx_fire       = tx_valid && tx_ready;
   assign addr_in_range = {1'b0, addr_q} < NREGS_L;

   // Out-of-range addresses match no slice and read as zero.
   always_comb begin
      rd_slice = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (rx_data[ADDR_BITS-1:0] == ADDR_BITS'(i)) rd_slice = reg_rdata[i*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      tx_sh_d = tx_sh_q;
      case (state_q)
         ST_IDLE: begin
            if (rx_fire) begin
               addr_d = rx_data[ADDR_BITS-1:0];
               cnt_d  = '0;
               if (rx_data[CMD_WRITE_BIT]) begin
                  state_d = ST_WDATA;
               end else begin
                  state_d                = ST_RDATA;
                  tx_sh_d                = '0;
                  tx_sh_d[WIDTH-1:0]     = rd_slice;
               end
            end
         end
         ST_WDATA: begin
            if (rx_fire) begin
               for (int b = 0; b < WIDTH; b++) begin
                  if (b / 8 == int'(cnt_q)) wdata_d[b] = rx_data[b % 8];
               end
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == LAST_BYTE) begin
                  cnt_d   = '0;
                  hold_d  = HOLD_LAST;
                  state_d = addr_in_range ? ST_WHOLD : ST_IDLE;
               end
            end
         end
         ST_WHOLD: begin
            if (hold_q == '0) state_d = ST_IDLE;
            else              hold_d  = hold_q - HW'(1);
         end
         ST_RDATA: begin
            if (tx_fire) begin
               tx_sh_d = tx_sh_q >> 8;
               cnt_d   = cnt_q + CW'(1);
               if (cnt_q == LAST_BYTE) begin
                  cnt_d   = '0;
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Mask is registered from the next state so it is glitch-free toward the bank.
   always_comb begin
      wmask_d = '0;
      if (state_d == ST_WHOLD) begin
         for (int i = 0; i < NREGS; i++) begin
            if (addr_d == ADDR_BITS'(i)) wmask_d[i*WIDTH +: WIDTH] = '1;
         end
      end
   end

   always_ff @(posedge sclk or posedge srst) begin
      if (srst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         hold_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
         tx_sh_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
         tx_sh_q <= tx_sh_d;
      end
   end

endmodule

// File: tb/tb_host_reg_port.sv
// Bench for host_reg_port: directed cases plus random write/read traffic against a register model.
module tb_host_reg_port;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [63:0] wmask;
   logic [15:0] wdata;
   logic [63:0] bank = '0;

   logic [7:0]  rx12_data = '0;
   logic        rx12_valid = 1'b0;
   logic        rx12_ready;
   logic [7:0]  tx12_data;
   logic        tx12_valid;
   logic        tx12_ready = 1'b1;
   logic [47:0] wmask12;
   logic [11:0] wdata12;
   logic [47:0] bank12 = '0;

   logic [15:0] exp_regs [4];
   int checks = 0;
   int failures = 0;

   host_reg_port #(.NREGS(4), .WIDTH(16), .WR_HOLD(8)) dut (
      .sclk(clk), .srst(rst),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .reg_wmask(wmask), .reg_wdata(wdata), .reg_rdata(bank)
   );

   host_reg_port #(.NREGS(4), .WIDTH(12), .WR_HOLD(8)) dut12 (
      .sclk(clk), .srst(rst),
      .rx_data(rx12_data), .rx_valid(rx12_valid), .rx_ready(rx12_ready),
      .tx_data(tx12_data), .tx_valid(tx12_valid), .tx_ready(tx12_ready),
      .reg_wmask(wmask12), .reg_wdata(wdata12), .reg_rdata(bank12)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting posedge.
   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      chk("rx_ready_before_byte", rx_ready, 1);
      @(posedge clk);
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send12(input logic [7:0] b);
      rx12_data  = b;
      rx12_valid = 1'b1;
      chk("rx12_ready_before_byte", rx12_ready, 1);
      @(posedge clk);
      @(negedge clk);
      rx12_valid = 1'b0;
   endtask

   // Mask pulse on the addressed slice must cover exactly cycles 0..7 after the last byte.
   task automatic do_write(input logic [6:0] a, input logic [15:0] d);
      int hits, stray, rdy_bad;
      logic inr;
      logic [15:0] sl;
      inr = (a < 7'd4);
      send_byte({1'b1, a});
      send_byte(d[7:0]);
      send_byte(d[15:8]);
      chk("wr_wdata", wdata, d);
      hits = 0; stray = 0; rdy_bad = 0;
      for (int i = 0; i < 10; i++) begin
         for (int r = 0; r < 4; r++) begin
            sl = wmask[r*16 +: 16];
            if (sl == 16'hFFFF) begin
               if (inr && r == int'(a) && i < 8) hits++;
               else stray++;
               bank[r*16 +: 16] = wdata;
            end else if (sl != 16'h0) begin
               stray++;
            end
         end
         if (rx_ready !== ((inr && i < 8) ? 1'b0 : 1'b1)) rdy_bad++;
         @(negedge clk);
      end
      chk("wr_mask_cycles", hits, inr ? 8 : 0);
      chk("wr_mask_stray", stray, 0);
      chk("wr_rx_ready_pattern", rdy_bad, 0);
      if (inr) exp_regs[a[1:0]] = d;
   endtask

   task automatic do_read(input logic [6:0] a, input logic [15:0] exp, input int stall, input bit clobber);
      int k, budget, stall_left;
      logic [15:0] e;
      e = exp;
      stall_left = stall;
      tx_ready = 1'b0;
      send_byte({1'b0, a});
      if (clobber && a < 7'd4) begin
         bank[int'(a)*16 +: 16] = 16'h0000;
         exp_regs[a[1:0]] = 16'h0000;
      end
      k = 0; budget = 0;
      while (k < 2 && budget < 100) begin
         chk("rd_tx_valid", tx_valid, 1);
         chk("rd_tx_data", tx_data, (k == 0) ? e[7:0] : e[15:8]);
         chk("rd_rx_ready", rx_ready, 0);
         if (stall_left > 0) begin
            tx_ready = 1'b0;
            stall_left--;
         end else begin
            tx_ready = ($urandom_range(0, 3) != 0);
         end
         if (tx_ready) k++;
         @(negedge clk);
         budget++;
      end
      tx_ready = 1'b0;
      chk("rd_bytes_done", k, 2);
      chk("rd_tx_valid_fall", tx_valid, 0);
   endtask

   initial begin
      int pulses12, nz;
      logic [6:0]  ra;
      logic [15:0] rd;
      #200000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0]  ra;
      logic [15:0] rd;
      int nz, pulses12;
      for (int r = 0; r < 4; r++) begin
         exp_regs[r] = 16'($urandom);
         bank[r*16 +: 16] = exp_regs[r];
      end
      repeat (2) @(negedge clk);
      chk("rst_rx_ready", rx_ready, 0);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_wmask", wmask, 0);
      chk("rst_wdata", wdata, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_rx_ready", rx_ready, 1);

      do_write(7'd2, 16'h1234);
      chk("wr_bank_reg2", bank[47:32], 16'h1234);

      bank[31:16] = 16'hBEEF;
      exp_regs[1] = 16'hBEEF;
      do_read(7'd1, 16'hBEEF, 5, 1'b1);

      do_write(7'd5, 16'hBBAA);
      do_read(7'd6, 16'h0000, 0, 1'b0);

      send_byte(8'h83);
      send_byte(8'h55);
      rst = 1'b1;
      #1;
      chk("midwr_rst_wmask", wmask, 0);
      chk("midwr_rst_wdata", wdata, 0);
      chk("midwr_rst_rx_ready", rx_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      nz = 0;
      for (int i = 0; i < 10; i++) begin
         if (wmask != 64'h0) nz++;
         @(negedge clk);
      end
      chk("midwr_no_pulse", nz, 0);
      do_write(7'd0, 16'h0001);

      send_byte(8'h02);
      rst = 1'b1;
      #1;
      chk("midrd_rst_tx_valid", tx_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("midrd_idle_tx_valid", tx_valid, 0);
      chk("midrd_idle_rx_ready", rx_ready, 1);

      for (int n = 0; n < 40; n++) begin
         ra = 7'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1) begin
            do_write(ra, 16'($urandom));
         end else begin
            rd = (ra < 7'd4) ? exp_regs[ra[1:0]] : 16'h0000;
            do_read(ra, rd, $urandom_range(0, 3), 1'b0);
         end
      end

      send12(8'h80);
      send12(8'hCD);
      send12(8'hFB);
      chk("w12_wdata", wdata12, 12'hBCD);
      pulses12 = 0;
      for (int i = 0; i < 10; i++) begin
         if (wmask12[11:0] == 12'hFFF && wmask12[47:12] == '0) pulses12++;
         @(negedge clk);
      end
      chk("w12_mask_cycles", pulses12, 8);
      bank12[35:24] = 12'hBCD;
      tx12_ready = 1'b1;
      send12(8'h02);
      chk("r12_valid0", tx12_valid, 1);
      chk("r12_byte0", tx12_data, 8'hCD);
      @(negedge clk);
      chk("r12_valid1", tx12_valid, 1);
      chk("r12_byte1", tx12_data, 8'h0B);
      @(negedge clk);
      chk("r12_valid_fall", tx12_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
